// File: rtl/uart_program_loader.sv
// UART boot loader: receives a framed program image and writes 16-bit words into instruction memory.
// Optional frame checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_program_loader #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WORDS  = 256,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  prog_we,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [15:0]           prog_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = $clog2(BIT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERROR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t TAIL_ST = CHK;
`else
  localparam state_t TAIL_ST = DONE;
`endif

  // Two-flop synchronizer plus one delay stage for start-edge detection
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_valid_c, framing_err_c;
  logic [7:0]       rx_byte_c;

  assign rx_byte_c = rx_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // 8N1 receiver: mid-bit sampling, false-start rejection, stop-bit check
  always_comb begin
    rx_state_n    = rx_state;
    rx_cnt_n      = rx_cnt;
    rx_bit_n      = rx_bit;
    rx_shift_n    = rx_shift;
    rx_valid_c    = 1'b0;
    framing_err_c = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == CNT_W'(HALF_CYC - 1)) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = CNT_W'(rx_cnt + 1'b1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_W'(BIT_CYC - 1)) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_bit_n   = 3'(rx_bit + 1'b1);
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end else begin
          rx_cnt_n = CNT_W'(rx_cnt + 1'b1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_W'(BIT_CYC - 1)) begin
          rx_cnt_n      = '0;
          rx_state_n    = RX_IDLE;
          rx_valid_c    = rx_sync;
          framing_err_c = !rx_sync;
        end else begin
          rx_cnt_n = CNT_W'(rx_cnt + 1'b1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  state_t                state, state_n;
  logic [7:0]            len_hi_q, len_hi_n;
  logic [15:0]           rem_q, rem_n;
  logic [7:0]            hi_q, hi_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [15:0]           data_n;
  logic                  we_n, hold_n, busy_n, done_n, err_n;
  logic [15:0]           len_c;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_n;
`endif

  assign len_c = {len_hi_q, rx_byte_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len_hi_q   <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state      <= state_n;
      len_hi_q   <= len_hi_n;
      rem_q      <= rem_n;
      hi_q       <= hi_n;
      prog_we    <= we_n;
      prog_addr  <= addr_n;
      prog_data  <= data_n;
      cpu_hold   <= hold_n;
      busy       <= busy_n;
      load_done  <= done_n;
      load_error <= err_n;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_n;
`endif
    end
  end

  // Frame parser; the address advances the cycle after each write strobe
  always_comb begin
    state_n  = state;
    len_hi_n = len_hi_q;
    rem_n    = rem_q;
    hi_n     = hi_q;
    addr_n   = prog_we ? ADDR_WIDTH'(prog_addr + 1'b1) : prog_addr;
    data_n   = prog_data;
    we_n     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_n    = sum_q;
`endif
    case (state)
      IDLE, DONE, ERROR: begin
        if (rx_valid_c && rx_byte_c == SYNC_BYTE) begin
          state_n = LEN_HI;
`ifdef LOADER_CHECKSUM_EN
          sum_n   = '0;
`endif
        end
      end
      LEN_HI: begin
        if (rx_valid_c) begin
          len_hi_n = rx_byte_c;
          state_n  = LEN_LO;
`ifdef LOADER_CHECKSUM_EN
          sum_n    = 8'(sum_q + rx_byte_c);
`endif
        end
      end
      LEN_LO: begin
        if (rx_valid_c) begin
          rem_n = len_c;
`ifdef LOADER_CHECKSUM_EN
          sum_n = 8'(sum_q + rx_byte_c);
`endif
          if ({1'b0, len_c} > 17'(MAX_WORDS)) begin
            state_n = ERROR;
          end else if (len_c == 16'd0) begin
            state_n = TAIL_ST;
          end else begin
            addr_n  = '0;
            state_n = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (rx_valid_c) begin
          hi_n    = rx_byte_c;
          state_n = DATA_LO;
`ifdef LOADER_CHECKSUM_EN
          sum_n   = 8'(sum_q + rx_byte_c);
`endif
        end
      end
      DATA_LO: begin
        if (rx_valid_c) begin
          data_n  = {hi_q, rx_byte_c};
          we_n    = 1'b1;
          rem_n   = 16'(rem_q - 16'd1);
          state_n = (rem_q == 16'd1) ? TAIL_ST : DATA_HI;
`ifdef LOADER_CHECKSUM_EN
          sum_n   = 8'(sum_q + rx_byte_c);
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (rx_valid_c) begin
          state_n = (8'(sum_q + rx_byte_c) == 8'd0) ? DONE : ERROR;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    // busy mirrors "current state is inside a frame"
    if (framing_err_c && busy) state_n = ERROR;
    busy_n = !(state_n inside {IDLE, DONE, ERROR});
    hold_n = (state_n != DONE);
    done_n = (state_n == DONE);
    err_n  = (state_n == ERROR);
  end

endmodule
